irq_entry_sequencer: RTL

//  Consumes INT_irq from the interrupt request circuit and runs the ARM IRQ entry sequence at an instruction boundary.

---
 rtl/arm_cpu_defs.sv | 27 ++
 rtl/irq_entry_stats.sv | 47 ++++
 rtl/irq_entry_sequencer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/arm_cpu_defs.sv
// rtl/arm_cpu_defs.sv - shared ARM CPU constants, IRQ entry state encoding and CPSR helper
package arm_cpu_defs;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_SAVE = 2'b10,
    ST_VECT = 2'b11
  } irq_state_e;

  localparam logic [4:0] MODE_IRQ   = 5'b10010;
  localparam logic [1:0] PC_S_SEQ   = 2'b00;
  localparam logic [1:0] PC_S_VEC   = 2'b11;
  localparam int         CPSR_I_BIT = 7;
  localparam int         CPSR_T_BIT = 5;

  // CPSR image on IRQ entry: new mode, IRQs masked, ARM state; flags and F bit untouched
  function automatic logic [31:0] irq_entry_cpsr(input logic [31:0] cpsr, input logic [4:0] mode);
    logic [31:0] r;
    r             = cpsr;
    r[4:0]        = mode;
    r[CPSR_T_BIT] = 1'b0;
    r[CPSR_I_BIT] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/irq_entry_stats.sv
// rtl/irq_entry_stats.sv - IRQ entry count and worst-case wait latency (only with IRQ_ENTRY_STATS_EN)
`ifdef IRQ_ENTRY_STATS_EN
module irq_entry_stats
  import arm_cpu_defs::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  irq_state_e  state_d,
  output logic [15:0] irq_count,
  output logic [7:0]  max_lat
);

  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  lat_q, lat_d;
  logic [7:0]  max_q, max_d;

  // Latency counts cycles the request spends held off in WAIT; folded into the max on SAVE
  always_comb begin
    cnt_d = cnt_q;
    lat_d = 8'd0;
    max_d = max_q;
    if (state_d == ST_WAIT) begin
      lat_d = (lat_q == 8'hFF) ? lat_q : lat_q + 8'd1;
    end else if (state_d == ST_SAVE) begin
      if (lat_q > max_q) max_d = lat_q;
      if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    end
  end

  // Statistic registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 16'd0;
      lat_q <= 8'd0;
      max_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
      lat_q <= lat_d;
      max_q <= max_d;
    end
  end

  assign irq_count = cnt_q;
  assign max_lat   = max_q;

endmodule
`endif

// File: rtl/irq_entry_sequencer.sv
// rtl/irq_entry_sequencer.sv - ARM IRQ entry sequencer; optional statistics via IRQ_ENTRY_STATS_EN
module irq_entry_sequencer
  import arm_cpu_defs::*;
#(
  parameter logic [31:0] VECTOR_ADDR = 32'h0000_0018,
  parameter logic [31:0] LR_OFFSET   = 32'd4,
  parameter logic [4:0]  IRQ_MODE    = MODE_IRQ
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        INT_irq,
  input  logic        instr_bnd,
  input  logic [31:0] next_pc,
  input  logic [31:0] cpsr_in,
  output logic        INTA_irq,
  output logic        stall,
  output logic        Write_SPSR,
  output logic [31:0] spsr_data,
  output logic        Write_LR,
  output logic [31:0] lr_data,
  output logic        Write_CPSR,
  output logic [31:0] cpsr_data,
  output logic        Write_PC,
  output logic [1:0]  PC_s,
  output logic [31:0] vec_addr
`ifdef IRQ_ENTRY_STATS_EN
  ,
  output logic [15:0] irq_count,
  output logic [7:0]  max_lat
`endif
);

  irq_state_e  state_q, state_d;
  logic [31:0] spsr_q, spsr_d;
  logic [31:0] lr_q, lr_d;
  logic [31:0] cpsr_q, cpsr_d;
  logic        capture;

  // Next state; capture happens on the single cycle that commits to SAVE
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (INT_irq && instr_bnd) begin
          state_d = ST_SAVE;
          capture = 1'b1;
        end else if (INT_irq) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A withdrawn request wins over a coincident boundary: nothing to service
        if (!INT_irq) begin
          state_d = ST_IDLE;
        end else if (instr_bnd) begin
          state_d = ST_SAVE;
          capture = 1'b1;
        end
      end
      ST_SAVE: state_d = ST_VECT;
      ST_VECT: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Capture register next values
  always_comb begin
    spsr_d = spsr_q;
    lr_d   = lr_q;
    cpsr_d = cpsr_q;
    if (capture) begin
      spsr_d = cpsr_in;
      lr_d   = next_pc + LR_OFFSET;
      cpsr_d = irq_entry_cpsr(cpsr_in, IRQ_MODE);
    end
  end

  // State and capture registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      spsr_q  <= 32'd0;
      lr_q    <= 32'd0;
      cpsr_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      spsr_q  <= spsr_d;
      lr_q    <= lr_d;
      cpsr_q  <= cpsr_d;
    end
  end

  // Strobes decode from the state register only, so reset drops them immediately
  always_comb begin
    INTA_irq   = 1'b0;
    stall      = 1'b0;
    Write_SPSR = 1'b0;
    Write_LR   = 1'b0;
    Write_CPSR = 1'b0;
    Write_PC   = 1'b0;
    PC_s       = PC_S_SEQ;
    case (state_q)
      ST_SAVE: begin
        INTA_irq   = 1'b1;
        Write_SPSR = 1'b1;
        Write_LR   = 1'b1;
        stall      = 1'b1;
      end
      ST_VECT: begin
        Write_CPSR = 1'b1;
        Write_PC   = 1'b1;
        PC_s       = PC_S_VEC;
        stall      = 1'b1;
      end
      default: ;
    endcase
  end

  assign spsr_data = spsr_q;
  assign lr_data   = lr_q;
  assign cpsr_data = cpsr_q;
  assign vec_addr  = VECTOR_ADDR;

`ifdef IRQ_ENTRY_STATS_EN
  irq_entry_stats u_stats (
    .clk       (clk),
    .rst_n     (rst),
    .state_d   (state_d),
    .irq_count (irq_count),
    .max_lat   (max_lat)
  );
`endif

endmodule
